// File: rtl/ps2_kbd_event_rx_if.sv
// PS/2 keyboard receiver bus: keyboard pins and read strobe in, FIFO head and status out.
interface ps2_kbd_event_rx_if #(
    parameter int FIFO_AW = 3
);
    logic               ps2_clk;
    logic               ps2_data;
    logic               nextdata_n;
    logic [9:0]         data;
    logic               ready;
    logic [FIFO_AW:0]   count;
    logic               overflow;
    logic               frame_err;

    modport master (
        output ps2_clk, ps2_data, nextdata_n,
        input  data, ready, count, overflow, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, nextdata_n,
        output data, ready, count, overflow, frame_err
    );
endinterface

// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver: checked 11-bit frames, E0/F0 prefix folding, FWFT event FIFO.
// Push lands one cycle after the stop-bit edge is seen; a full FIFO drops the push and sets overflow.
module ps2_kbd_event_rx #(
    parameter int FIFO_AW        = 3,
    parameter int PARITY_CHECK   = 1,
    parameter int DECODE_EVENTS  = 1,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                 clk,
    input  logic                 clr,
    ps2_kbd_event_rx_if.slave    bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} dec_st_t;

    logic [2:0]         clk_sync_q, clk_sync_d;
    logic [1:0]         dat_sync_q, dat_sync_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [9:0]         shift_q, shift_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               byte_vld_q, byte_vld_d;
    logic [7:0]         byte_q, byte_d;
    logic               err_q, err_d;
    dec_st_t            st_q, st_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               nd_q, nd_d;
    logic               nd_prev_q, nd_prev_d;

    logic [9:0]         mem [DEPTH];

    logic               fall;
    logic               din;
    logic               frame_ok;
    logic               push_vld;
    logic [9:0]         push_dat;
    logic               pop;
    logic               full;
    logic               wr_en;

    // Frame reception and inactivity timeout
    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], bus.ps2_clk};
        dat_sync_d = {dat_sync_q[0], bus.ps2_data};
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        timer_d    = timer_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        err_d      = 1'b0;

        fall     = (clk_sync_q[2:1] == 2'b10);
        din      = dat_sync_q[1];
        // shift_q holds start in [0], data in [8:1], parity in [9]; din is the stop bit
        frame_ok = !shift_q[0] && din && ((^shift_q[9:1]) || (PARITY_CHECK == 0));

        if (fall) begin
            timer_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d  = 4'd0;
                byte_vld_d = frame_ok;
                err_d      = !frame_ok;
                byte_d     = shift_q[8:1];
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shift_d   = {din, shift_q[9:1]};
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d = 4'd0;
                timer_d   = '0;
                err_d     = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    // Prefix folding decoder
    always_comb begin
        st_d     = st_q;
        push_vld = 1'b0;
        push_dat = '0;
        if (byte_vld_q) begin
            if (DECODE_EVENTS == 0) begin
                push_vld = 1'b1;
                push_dat = {2'b00, byte_q};
            end else begin
                case (byte_q)
                    8'hE0: st_d = ST_E0;
                    8'hF0: st_d = (st_q == ST_E0 || st_q == ST_E0F0) ? ST_E0F0 : ST_F0;
                    default: begin
                        push_vld = 1'b1;
                        push_dat = {(st_q == ST_E0 || st_q == ST_E0F0),
                                    (st_q == ST_F0 || st_q == ST_E0F0), byte_q};
                        st_d     = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO bookkeeping; a pop frees a slot for a same-cycle push on a full FIFO
    always_comb begin
        nd_d      = bus.nextdata_n;
        nd_prev_d = nd_q;
        pop       = nd_prev_q && !nd_q && (cnt_q != '0);
        full      = (cnt_q == (FIFO_AW + 1)'(DEPTH));
        wr_en     = push_vld && (!full || pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        if (wr_en && !pop)      cnt_d = cnt_q + (FIFO_AW + 1)'(1);
        else if (!wr_en && pop) cnt_d = cnt_q - (FIFO_AW + 1)'(1);

        if (pop)                      ovf_d = 1'b0;
        else if (push_vld && !wr_en)  ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            timer_q    <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            err_q      <= 1'b0;
            st_q       <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            nd_q       <= 1'b1;
            nd_prev_q  <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            timer_q    <= timer_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            err_q      <= err_d;
            st_q       <= st_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            nd_q       <= nd_d;
            nd_prev_q  <= nd_prev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= push_dat;
    end

    assign bus.ready     = (cnt_q != '0);
    assign bus.data      = bus.ready ? mem[rd_ptr_q] : 10'd0;
    assign bus.count     = cnt_q;
    assign bus.overflow  = ovf_q;
    assign bus.frame_err = err_q;
endmodule
